// File: rtl/conv1d_mac_pipeline.sv
// Four-stage signed multiply-accumulate datapath that turns operand beats into grouped psums.
// Optional build macro CONV1D_MAC_SATURATE_EN: saturating accumulate with a sticky Overflow flag.
module conv1d_mac_pipeline #(
  parameter int Data_Width           = 8,
  parameter int Acc_Width            = 24,
  parameter int L0_Output_Addr_Width = 3
) (
  input  logic                                   clk,
  input  logic                                   Comp_Reset,
  input  logic                                   Computing,
  input  logic                                   Initial_Accumulate,
  input  logic                                   Flush,
  input  logic signed [Data_Width-1:0]           Weight_Data,
  input  logic signed [Data_Width-1:0]           Input_Data,
  input  logic        [L0_Output_Addr_Width-1:0] Out_Addr,
  output logic                                   Psum_Valid,
  output logic signed [Acc_Width-1:0]            Psum_Data,
  output logic        [L0_Output_Addr_Width-1:0] Psum_Addr,
  output logic                                   Overflow,
  output logic                                   Busy
);

  localparam int PW = 2 * Data_Width;

  // Stage 1: captured beat
  logic                            s1_v_q, s1_ia_q, s1_fl_q;
  logic signed [Data_Width-1:0]    s1_w_q, s1_x_q;
  logic [L0_Output_Addr_Width-1:0] s1_addr_q;

  // Stage 2: product
  logic                            s2_v_q, s2_ia_q, s2_fl_q;
  logic signed [PW-1:0]            s2_p_q, s2_p_d;
  logic [L0_Output_Addr_Width-1:0] s2_addr_q;

  // Stage 3: open group state and psum output registers
  logic signed [Acc_Width-1:0]     acc_q, acc_d;
  logic [L0_Output_Addr_Width-1:0] grp_q, grp_d;
  logic                            has_q, has_d;
  logic                            emit;
  logic signed [Acc_Width-1:0]     emit_data;
  logic [L0_Output_Addr_Width-1:0] emit_addr;
  logic                            psum_valid_q;
  logic signed [Acc_Width-1:0]     psum_data_q;
  logic [L0_Output_Addr_Width-1:0] psum_addr_q;

  logic signed [Acc_Width-1:0]     p_ext;
  logic signed [Acc_Width-1:0]     sum_res;

  assign s2_p_d = PW'(s1_w_q) * PW'(s1_x_q);
  assign p_ext  = Acc_Width'(s2_p_q);

`ifdef CONV1D_MAC_SATURATE_EN
  logic signed [Acc_Width:0] sum_wide;
  logic                      sum_ovf;
  logic                      ovf_set;
  logic                      ovf_q;

  // One guard bit: the sum overflowed when the top two bits disagree.
  assign sum_wide = {acc_q[Acc_Width-1], acc_q} + {p_ext[Acc_Width-1], p_ext};
  assign sum_ovf  = sum_wide[Acc_Width] ^ sum_wide[Acc_Width-1];
  always_comb begin
    sum_res = sum_wide[Acc_Width-1:0];
    if (sum_ovf) begin
      sum_res = sum_wide[Acc_Width] ? {1'b1, {(Acc_Width-1){1'b0}}}
                                    : {1'b0, {(Acc_Width-1){1'b1}}};
    end
  end
  assign ovf_set = s2_v_q & ~s2_ia_q & has_q & sum_ovf;

  always_ff @(posedge clk) begin
    if (Comp_Reset) ovf_q <= 1'b0;
    else            ovf_q <= ovf_q | ovf_set;
  end
  assign Overflow = ovf_q;
`else
  assign sum_res  = acc_q + p_ext;
  assign Overflow = 1'b0;
`endif

  // Accumulate step; a flush on the same entry overrides an IA emit of the old group.
  always_comb begin
    acc_d     = acc_q;
    grp_d     = grp_q;
    has_d     = has_q;
    emit      = 1'b0;
    emit_data = acc_q;
    emit_addr = grp_q;
    if (s2_v_q) begin
      if (s2_ia_q) begin
        if (has_q) emit = 1'b1;
        acc_d = p_ext;
        grp_d = s2_addr_q;
        has_d = 1'b1;
      end else if (has_q) begin
        acc_d = sum_res;
      end
    end
    if (s2_fl_q) begin
      if (has_d) begin
        emit      = 1'b1;
        emit_data = acc_d;
        emit_addr = grp_d;
      end
      has_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Comp_Reset) begin
      s1_v_q       <= 1'b0;
      s1_ia_q      <= 1'b0;
      s1_fl_q      <= 1'b0;
      s1_w_q       <= '0;
      s1_x_q       <= '0;
      s1_addr_q    <= '0;
      s2_v_q       <= 1'b0;
      s2_ia_q      <= 1'b0;
      s2_fl_q      <= 1'b0;
      s2_p_q       <= '0;
      s2_addr_q    <= '0;
      acc_q        <= '0;
      grp_q        <= '0;
      has_q        <= 1'b0;
      psum_valid_q <= 1'b0;
      psum_data_q  <= '0;
      psum_addr_q  <= '0;
    end else begin
      s1_v_q       <= Computing;
      s1_ia_q      <= Initial_Accumulate;
      s1_fl_q      <= Flush;
      s1_w_q       <= Weight_Data;
      s1_x_q       <= Input_Data;
      s1_addr_q    <= Out_Addr;
      s2_v_q       <= s1_v_q;
      s2_ia_q      <= s1_ia_q;
      s2_fl_q      <= s1_fl_q;
      s2_p_q       <= s2_p_d;
      s2_addr_q    <= s1_addr_q;
      acc_q        <= acc_d;
      grp_q        <= grp_d;
      has_q        <= has_d;
      psum_valid_q <= emit;
      if (emit) begin
        psum_data_q <= emit_data;
        psum_addr_q <= emit_addr;
      end
    end
  end

  assign Psum_Valid = psum_valid_q;
  assign Psum_Data  = psum_data_q;
  assign Psum_Addr  = psum_addr_q;
  assign Busy       = s1_v_q | s1_fl_q | s2_v_q | s2_fl_q | has_q;

endmodule

// File: tb/tb_conv1d_mac_pipeline.sv
// Directed bench for conv1d_mac_pipeline: a beat-level group model predicts every psum and its cycle.
// Build with CONV1D_MAC_SATURATE_EN to expect saturating behaviour.
module tb_conv1d_mac_pipeline;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int ADW = 3;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                  Comp_Reset = 1'b1;
  logic                  Computing = 1'b0, Initial_Accumulate = 1'b0, Flush = 1'b0;
  logic signed [DW-1:0]  Weight_Data = '0, Input_Data = '0;
  logic        [ADW-1:0] Out_Addr = '0;
  logic                  Psum_Valid;
  logic signed [AW-1:0]  Psum_Data;
  logic        [ADW-1:0] Psum_Addr;
  logic                  Overflow, Busy;

  conv1d_mac_pipeline #(.Data_Width(DW), .Acc_Width(AW), .L0_Output_Addr_Width(ADW)) dut (
    .clk(clk), .Comp_Reset(Comp_Reset), .Computing(Computing),
    .Initial_Accumulate(Initial_Accumulate), .Flush(Flush),
    .Weight_Data(Weight_Data), .Input_Data(Input_Data), .Out_Addr(Out_Addr),
    .Psum_Valid(Psum_Valid), .Psum_Data(Psum_Data), .Psum_Addr(Psum_Addr),
    .Overflow(Overflow), .Busy(Busy)
  );

  // Scoreboard: expected psums with the cycle they must appear in
  logic [AW-1:0]  exp_q[$];
  logic [ADW-1:0] exp_addr_q[$];
  int             exp_due_q[$];
  int n_checks = 0, n_fail = 0, n_psum = 0;
  logic signed [AW-1:0] last_data = '0;
  logic [ADW-1:0]       last_addr = '0;
  bit chk_en = 0;

  // Group model: plain integer arithmetic on whole groups
  longint   m_acc = 0;
  int       m_grp = 0;
  bit       m_has = 0;

  function automatic longint acc_add(longint a, longint p);
    longint s;
    logic [AW-1:0] t;
    s = a + p;
`ifdef CONV1D_MAC_SATURATE_EN
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    t = s[AW-1:0];
    return longint'($signed(t));
`endif
  endfunction

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input longint data, input int addr);
    exp_q.push_back(data[AW-1:0]);
    exp_addr_q.push_back(addr[ADW-1:0]);
    exp_due_q.push_back(cyc + 3);
  endtask

  // Driver: one beat per cycle, model updated as the beat is presented
  task automatic beat(input bit v, input bit ia, input bit fl, input int w, input int x, input int addr);
    longint p;
    @(posedge clk); #1;
    Comp_Reset         = 1'b0;
    Computing          = v;
    Initial_Accumulate = ia;
    Flush              = fl;
    Weight_Data        = DW'(w);
    Input_Data         = DW'(x);
    Out_Addr           = ADW'(addr);
    p = longint'(w * x);
    if (v) begin
      if (ia) begin
        if (m_has && !fl) push_exp(m_acc, m_grp);
        m_acc = p;
        m_grp = addr;
        m_has = 1;
      end else if (m_has) begin
        m_acc = acc_add(m_acc, p);
      end
    end
    if (fl) begin
      if (m_has) push_exp(m_acc, m_grp);
      m_has = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) beat(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      Comp_Reset = 1'b1;
      Computing = 1'b0; Initial_Accumulate = 1'b0; Flush = 1'b0;
      Weight_Data = '0; Input_Data = '0; Out_Addr = '0;
      while (exp_due_q.size() > 0 && exp_due_q[$] >= cyc + 1) begin
        void'(exp_q.pop_back()); void'(exp_addr_q.pop_back()); void'(exp_due_q.pop_back());
      end
      m_has = 0;
      m_acc = 0;
    end
  endtask

  // Compare process: every cycle, strobe presence, data and address
  always @(negedge clk) begin
    if (chk_en) begin
      while (exp_due_q.size() > 0 && exp_due_q[0] < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL psum_late: expected psum %0d due cycle %0d never seen", $signed(exp_q[0]), exp_due_q[0]);
        void'(exp_q.pop_front()); void'(exp_addr_q.pop_front()); void'(exp_due_q.pop_front());
      end
      n_checks++;
      if (Psum_Valid === 1'b1) begin
        n_psum++;
        last_data = Psum_Data;
        last_addr = Psum_Addr;
        if (exp_due_q.size() == 0 || exp_due_q[0] != cyc) begin
          n_fail++;
          $display("FAIL psum_strobe: got Psum_Valid=1 data %0d addr %0d at cycle %0d, expected no psum",
                   Psum_Data, Psum_Addr, cyc);
        end else begin
          check("psum_data", Psum_Data, $signed(exp_q[0]));
          check("psum_addr", Psum_Addr, exp_addr_q[0]);
          void'(exp_q.pop_front()); void'(exp_addr_q.pop_front()); void'(exp_due_q.pop_front());
        end
      end else if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
        n_fail++;
        $display("FAIL psum_strobe: got Psum_Valid=%b at cycle %0d, expected psum %0d", Psum_Valid, cyc, $signed(exp_q[0]));
        void'(exp_q.pop_front()); void'(exp_addr_q.pop_front()); void'(exp_due_q.pop_front());
      end
`ifndef CONV1D_MAC_SATURATE_EN
      check("overflow_tied", Overflow, 0);
`endif
    end
  end

  int p0;

  initial begin
    // Reset held for 3 cycles
    do_reset(3);
    @(negedge clk);
    check("rst_valid", Psum_Valid, 0);
    check("rst_data", Psum_Data, 0);
    check("rst_addr", Psum_Addr, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_busy", Busy, 0);
    chk_en = 1;

    // Single group: 1*5+2*6+3*7+4*8 = 70 at address 3
    p0 = n_psum;
    beat(1, 1, 0, 1, 5, 3);
    beat(1, 0, 0, 2, 6, 0);
    beat(1, 0, 0, 3, 7, 0);
    beat(1, 0, 0, 4, 8, 0);
    @(negedge clk);
    check("grp_busy", Busy, 1);
    beat(0, 0, 1, 0, 0, 0);
    idle(5);
    @(negedge clk);
    check("grp_count", n_psum - p0, 1);
    check("grp_data", last_data, 70);
    check("grp_addr", last_addr, 3);
    check("grp_hold", Psum_Data, 70);
    check("grp_idle", Busy, 0);

    // Back-to-back groups: -6 @0 then 20 @1 on consecutive cycles
    p0 = n_psum;
    beat(1, 1, 0, 2, -3, 0);
    beat(1, 1, 0, -4, -5, 1);
    beat(0, 0, 1, 0, 0, 0);
    idle(5);
    @(negedge clk);
    check("b2b_count", n_psum - p0, 2);
    check("b2b_data", last_data, 20);
    check("b2b_addr", last_addr, 1);

    // Length-1 groups each cycle: 1, 4, 9
    p0 = n_psum;
    beat(1, 1, 0, 1, 1, 0);
    beat(1, 1, 0, 2, 2, 1);
    beat(1, 1, 0, 3, 3, 2);
    beat(0, 0, 1, 0, 0, 0);
    idle(5);
    @(negedge clk);
    check("len1_count", n_psum - p0, 3);
    check("len1_data", last_data, 9);

    // IA and Flush on one beat with an open group: only the flushed single product (1 @6)
    p0 = n_psum;
    beat(1, 1, 0, 5, 5, 2);
    beat(1, 1, 1, 1, 1, 6);
    idle(5);
    @(negedge clk);
    check("iafl_count", n_psum - p0, 1);
    check("iafl_data", last_data, 1);
    check("iafl_addr", last_addr, 6);

    // Orphan beats: no open group, nothing emitted
    p0 = n_psum;
    beat(1, 0, 0, 3, 3, 0);
    beat(1, 0, 0, 4, 4, 0);
    beat(0, 0, 1, 0, 0, 0);
    idle(5);
    @(negedge clk);
    check("orphan_count", n_psum - p0, 0);

    // Bubbles inside a group: 10 + 20 - 3 = 27 @5
    p0 = n_psum;
    beat(1, 1, 0, 1, 10, 5);
    beat(0, 0, 0, 50, 50, 0);
    beat(1, 0, 0, 2, 10, 0);
    beat(0, 1, 0, -7, 9, 1);
    beat(1, 0, 1, 3, -1, 0);
    idle(5);
    @(negedge clk);
    check("bubble_count", n_psum - p0, 1);
    check("bubble_data", last_data, 27);
    check("bubble_addr", last_addr, 5);

    // Reset mid-group: accumulated group and in-flight beats are discarded
    p0 = n_psum;
    beat(1, 1, 0, 1, 1, 4);
    beat(1, 0, 0, 1, 1, 0);
    idle(3);
    @(negedge clk);
    check("midrst_busy_pre", Busy, 1);
    do_reset(1);
    beat(0, 0, 1, 0, 0, 0);
    idle(5);
    beat(1, 1, 0, 2, 2, 1);
    beat(1, 0, 1, 1, 1, 0);
    do_reset(1);
    idle(5);
    @(negedge clk);
    check("midrst_count", n_psum - p0, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_data", Psum_Data, 0);

    // Overflow: three beats of 127*127 = 48387 total
    p0 = n_psum;
    beat(1, 1, 0, 127, 127, 7);
    beat(1, 0, 0, 127, 127, 0);
    beat(1, 0, 0, 127, 127, 0);
    beat(0, 0, 1, 0, 0, 0);
    idle(5);
    @(negedge clk);
    check("ovf_count", n_psum - p0, 1);
    check("ovf_addr", last_addr, 7);
`ifdef CONV1D_MAC_SATURATE_EN
    check("ovf_data", last_data, 32767);
    check("ovf_flag", Overflow, 1);
    do_reset(1);
    @(negedge clk);
    check("ovf_flag_clr", Overflow, 0);
`else
    check("ovf_data", last_data, -17149);
    check("ovf_flag", Overflow, 0);
`endif
    check("final_busy", Busy, 0);
    check("final_queue", exp_due_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
